// File: rtl/osd_event_arbiter.sv
// osd_event_arbiter: packet-atomic round-robin arbiter sharing one DII
// egress port between N debug-event sources. A granted source keeps the
// output until its last flit is accepted, so packets never interleave.

package osd_dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module osd_event_arbiter
    import osd_dii_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit [N-1:0]  in_i,
    output logic    [N-1:0]  in_ready_o,
    output dii_flit          out_o,
    input  logic             out_ready_i,
    output logic    [GW-1:0] grant_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   ptr_q;
    logic [GW-1:0]   ptr_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   grant_d;
    logic            any_valid;
    logic            pkt_done;
    logic [N-1:0]    vld;
    logic [2*N-1:0]  vld_rot;

    // Round-robin scan: first valid source at or after ptr, wrapping mod N.
    // The valid vector is doubled and shifted so the scan uses constant indices.
    always_comb begin
        vld       = '0;
        any_valid = 1'b0;
        grant_d   = grant_q;
        for (int unsigned i = 0; i < N; i++) begin
            vld[i] = in_i[i].valid;
        end
        vld_rot = {vld, vld} >> ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned sum;
            sum = 32'(ptr_q) + k;
            if (!any_valid && vld_rot[k]) begin
                any_valid = 1'b1;
                grant_d   = GW'((sum >= N) ? (sum - N) : sum);
            end
        end
    end

    // Zero-latency data path from the owner to the egress port while locked.
    always_comb begin
        out_o      = '0;
        in_ready_o = '0;
        if (state_q == LOCKED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (GW'(i) == grant_q) begin
                    out_o         = in_i[i];
                    in_ready_o[i] = out_ready_i;
                end
            end
        end
    end

    // Packet completion and the pointer value that follows it.
    always_comb begin
        pkt_done = (state_q == LOCKED) && out_o.valid && out_ready_i && out_o.last;
        ptr_d    = (grant_q == GW'(N - 1)) ? '0 : grant_q + GW'(1);
    end

    // Arbitration FSM: lock on a grant, release on the accepted last flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= grant_d;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_osd_event_arbiter.sv
// tb_osd_event_arbiter: directed self-checking bench for osd_event_arbiter
// (one N=3 instance and one N=4 instance sharing clock and reset).

module tb_osd_event_arbiter;
    import osd_dii_pkg::*;

    logic clk;
    logic rst;

    dii_flit [2:0] in3;
    logic    [2:0] in_ready3;
    dii_flit       out3;
    logic          out_ready3;
    logic    [1:0] grant3;
    logic          busy3;

    dii_flit [3:0] in4;
    logic    [3:0] in_ready4;
    dii_flit       out4;
    logic          out_ready4;
    logic    [1:0] grant4;
    logic          busy4;

    int n_checks;
    int n_fails;

    osd_event_arbiter #(.N(3)) u3 (
        .clk(clk), .rst(rst), .in_i(in3), .in_ready_o(in_ready3), .out_o(out3),
        .out_ready_i(out_ready3), .grant_o(grant3), .busy_o(busy3)
    );

    osd_event_arbiter #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_i(in4), .in_ready_o(in_ready4), .out_o(out4),
        .out_ready_i(out_ready4), .grant_o(grant4), .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dii_flit mk(input logic v, input logic l, input logic [15:0] d);
        dii_flit f;
        f.valid = v;
        f.last  = l;
        f.data  = d;
        return f;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (busy3 !== 1'b0) begin n_fails++; $display("FAIL rst_init_busy: got %b expected 0", busy3); end
        n_checks++; if (out3.valid !== 1'b0) begin n_fails++; $display("FAIL rst_init_valid: got %b expected 0", out3.valid); end
        n_checks++; if (in_ready3 !== 3'b000) begin n_fails++; $display("FAIL rst_init_ready: got %b expected 000", in_ready3); end
        rst = 1'b0;
        // single-flit packet from source 1 moves ptr to 2
        @(negedge clk); in3[1] = mk(1'b1, 1'b1, 16'hAAAA);
        @(negedge clk); #1;
        n_checks++; if (grant3 !== 2'd1 || busy3 !== 1'b1) begin n_fails++; $display("FAIL rst_pre_grant: got grant %0d busy %b expected 1 1", grant3, busy3); end
        @(negedge clk); in3[1] = '0; in3[2] = mk(1'b1, 1'b0, 16'hB000);
        @(negedge clk); out_ready3 = 1'b0; #1;
        n_checks++; if (grant3 !== 2'd2 || busy3 !== 1'b1) begin n_fails++; $display("FAIL rst_lock2: got grant %0d busy %b expected 2 1", grant3, busy3); end
        rst = 1'b1; #1;
        n_checks++; if (busy3 !== 1'b0) begin n_fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy3); end
        n_checks++; if (out3.valid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_valid: got %b expected 0", out3.valid); end
        n_checks++; if (in_ready3 !== 3'b000) begin n_fails++; $display("FAIL rst_mid_ready: got %b expected 000", in_ready3); end
        @(negedge clk);
        rst = 1'b0; out_ready3 = 1'b1;
        in3[1] = mk(1'b1, 1'b1, 16'hC001); in3[2] = mk(1'b1, 1'b1, 16'hC002);
        @(negedge clk); #1;
        n_checks++; if (grant3 !== 2'd1 || busy3 !== 1'b1) begin n_fails++; $display("FAIL rst_first_grant: got grant %0d busy %b expected 1 1", grant3, busy3); end
        n_checks++; if (out3.data !== 16'hC001) begin n_fails++; $display("FAIL rst_first_data: got %h expected c001", out3.data); end
        @(negedge clk); in3 = '0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [15:0] d [3];
        d = '{16'h1111, 16'h2222, 16'h3333};
        @(negedge clk); in3[1] = mk(1'b1, 1'b0, d[0]); #1;
        n_checks++; if (busy3 !== 1'b0 || in_ready3 !== 3'b000) begin n_fails++; $display("FAIL single_idle: got busy %b ready %b expected 0 000", busy3, in_ready3); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in3[1] = mk(1'b1, k == 2, d[k]); #1;
            n_checks++; if (out3.valid !== 1'b1 || out3.data !== d[k] || out3.last !== (k == 2)) begin
                n_fails++; $display("FAIL single_flit%0d: got v%b l%b %h expected v1 l%b %h", k, out3.valid, out3.last, out3.data, k == 2, d[k]);
            end
            n_checks++; if (grant3 !== 2'd1 || in_ready3 !== 3'b010) begin n_fails++; $display("FAIL single_own%0d: got grant %0d ready %b expected 1 010", k, grant3, in_ready3); end
        end
        @(negedge clk); in3[1] = '0; #1;
        n_checks++; if (busy3 !== 1'b0) begin n_fails++; $display("FAIL single_done_busy: got %b expected 0", busy3); end
        n_checks++; if (u3.ptr_q !== 2'd2) begin n_fails++; $display("FAIL single_ptr: got %0d expected 2", u3.ptr_q); end
    endtask

    task automatic test_contention;
        int          cnt [3];
        int          exp_g [13];
        logic [15:0] exp_d [13];
        exp_g = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 0, 0, -1};
        exp_d = '{16'h0, 16'h0000, 16'h0001, 16'h0, 16'h1000, 16'h1001, 16'h0,
                  16'h2000, 16'h2001, 16'h0, 16'h0002, 16'h0003, 16'h0};
        cnt = '{0, 0, 0};
        @(negedge clk); rst = 1'b1; #2; rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (c == 12) in3[i] = '0;
                else in3[i] = mk(1'b1, cnt[i][0], {4'(i), 12'(cnt[i])});
            end
            #1;
            n_checks++; if (busy3 !== (exp_g[c] >= 0)) begin n_fails++; $display("FAIL cont_busy c%0d: got %b expected %b", c, busy3, exp_g[c] >= 0); end
            if (exp_g[c] >= 0) begin
                n_checks++; if (grant3 !== 2'(exp_g[c]) || out3.data !== exp_d[c] || out3.valid !== 1'b1) begin
                    n_fails++; $display("FAIL cont_flit c%0d: got grant %0d data %h v%b expected %0d %h v1", c, grant3, out3.data, out3.valid, exp_g[c], exp_d[c]);
                end
            end else begin
                n_checks++; if (out3.valid !== 1'b0) begin n_fails++; $display("FAIL cont_gap c%0d: got valid %b expected 0", c, out3.valid); end
            end
            for (int i = 0; i < 3; i++) if (in_ready3[i] && in3[i].valid) cnt[i]++;
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk); in3[0] = mk(1'b1, 1'b0, 16'h4001);
        @(negedge clk); #1;
        n_checks++; if (out3.data !== 16'h4001 || grant3 !== 2'd0) begin n_fails++; $display("FAIL bp_f1: got %h grant %0d expected 4001 0", out3.data, grant3); end
        @(negedge clk); in3[0] = mk(1'b1, 1'b0, 16'h4002); #1;
        n_checks++; if (out3.data !== 16'h4002) begin n_fails++; $display("FAIL bp_f2: got %h expected 4002", out3.data); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); in3[0] = mk(1'b1, 1'b0, 16'h4003); out_ready3 = 1'b0; #1;
            n_checks++; if (out3.valid !== 1'b1 || out3.data !== 16'h4003 || in_ready3 !== 3'b000 || grant3 !== 2'd0 || busy3 !== 1'b1) begin
                n_fails++; $display("FAIL bp_stall%0d: got v%b %h ready %b grant %0d busy %b expected v1 4003 000 0 1", k, out3.valid, out3.data, in_ready3, grant3, busy3);
            end
        end
        @(negedge clk); out_ready3 = 1'b1; #1;
        n_checks++; if (out3.data !== 16'h4003 || in_ready3 !== 3'b001) begin n_fails++; $display("FAIL bp_f3: got %h ready %b expected 4003 001", out3.data, in_ready3); end
        @(negedge clk); in3[0] = mk(1'b1, 1'b1, 16'h4004); #1;
        n_checks++; if (out3.data !== 16'h4004 || out3.last !== 1'b1 || grant3 !== 2'd0) begin n_fails++; $display("FAIL bp_f4: got %h l%b grant %0d expected 4004 l1 0", out3.data, out3.last, grant3); end
        @(negedge clk); in3[0] = '0; #1;
        n_checks++; if (busy3 !== 1'b0) begin n_fails++; $display("FAIL bp_done: got busy %b expected 0", busy3); end
    endtask

    task automatic test_bubble;
        @(negedge clk); in3[0] = mk(1'b1, 1'b0, 16'h6001);
        @(negedge clk); in3[1] = mk(1'b1, 1'b1, 16'h7001); #1;
        n_checks++; if (grant3 !== 2'd0 || out3.data !== 16'h6001 || in_ready3 !== 3'b001) begin n_fails++; $display("FAIL bub_f1: got grant %0d %h ready %b expected 0 6001 001", grant3, out3.data, in_ready3); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); in3[0] = mk(1'b0, 1'b0, 16'h6002); #1;
            n_checks++; if (busy3 !== 1'b1 || grant3 !== 2'd0 || out3.valid !== 1'b0 || in_ready3[1] !== 1'b0) begin
                n_fails++; $display("FAIL bub_hold%0d: got busy %b grant %0d v%b ready1 %b expected 1 0 v0 0", k, busy3, grant3, out3.valid, in_ready3[1]);
            end
        end
        @(negedge clk); in3[0] = mk(1'b1, 1'b1, 16'h6002); #1;
        n_checks++; if (out3.valid !== 1'b1 || out3.data !== 16'h6002 || grant3 !== 2'd0) begin n_fails++; $display("FAIL bub_last: got v%b %h grant %0d expected v1 6002 0", out3.valid, out3.data, grant3); end
        @(negedge clk); in3[0] = '0; #1;
        n_checks++; if (busy3 !== 1'b0) begin n_fails++; $display("FAIL bub_gap: got busy %b expected 0", busy3); end
        @(negedge clk); #1;
        n_checks++; if (grant3 !== 2'd1 || out3.data !== 16'h7001 || busy3 !== 1'b1) begin n_fails++; $display("FAIL bub_next: got grant %0d %h busy %b expected 1 7001 1", grant3, out3.data, busy3); end
        @(negedge clk); in3[1] = '0;
    endtask

    task automatic test_wrap;
        @(negedge clk); in4[2] = mk(1'b1, 1'b1, 16'h8002);
        @(negedge clk); #1;
        n_checks++; if (grant4 !== 2'd2 || busy4 !== 1'b1) begin n_fails++; $display("FAIL wrap_pre: got grant %0d busy %b expected 2 1", grant4, busy4); end
        @(negedge clk);
        in4[2] = '0; in4[3] = mk(1'b1, 1'b1, 16'h8003); in4[0] = mk(1'b1, 1'b1, 16'h8000); #1;
        n_checks++; if (u4.ptr_q !== 2'd3 || busy4 !== 1'b0) begin n_fails++; $display("FAIL wrap_ptr3: got ptr %0d busy %b expected 3 0", u4.ptr_q, busy4); end
        @(negedge clk); #1;
        n_checks++; if (grant4 !== 2'd3 || out4.data !== 16'h8003 || in_ready4 !== 4'b1000) begin n_fails++; $display("FAIL wrap_g3: got grant %0d %h ready %b expected 3 8003 1000", grant4, out4.data, in_ready4); end
        @(negedge clk); in4[3] = '0; #1;
        n_checks++; if (u4.ptr_q !== 2'd0 || busy4 !== 1'b0) begin n_fails++; $display("FAIL wrap_ptr0: got ptr %0d busy %b expected 0 0", u4.ptr_q, busy4); end
        @(negedge clk); #1;
        n_checks++; if (grant4 !== 2'd0 || out4.data !== 16'h8000) begin n_fails++; $display("FAIL wrap_g0: got grant %0d %h expected 0 8000", grant4, out4.data); end
        @(negedge clk); in4[0] = '0; #1;
        n_checks++; if (busy4 !== 1'b0) begin n_fails++; $display("FAIL wrap_done: got busy %b expected 0", busy4); end
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        in3        = '0;
        in4        = '0;
        out_ready3 = 1'b1;
        out_ready4 = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_bubble();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
